// File: rtl/fl_netcope_remover_pkg.sv
//------------------------------------------------------------------------------
// Module   : fl_netcope_remover_pkg
// Brief    : Shared types and constants for the NetCOPE header remover.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fl_netcope_remover_pkg;

  localparam int CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    HEADER   = 2'd1,
    PAYLOAD  = 2'd2
  } state_t;

  // An 8-bit bus has no byte lanes to select, but keeps a 1-bit REM port.
  function automatic int rem_width(input int data_width);
    int w;
    w = $clog2(data_width / 8);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fl_out_reg.sv
//------------------------------------------------------------------------------
// Module   : fl_out_reg
// Brief    : Single-entry ready/valid register for a FrameLink word + delimiters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fl_out_reg #(
  parameter int DATA_WIDTH = 64,
  parameter int REM_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_vld,
  output logic                  rx_rdy,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic [REM_WIDTH-1:0]  rx_rem,
  input  logic                  rx_sof_n,
  input  logic                  rx_eof_n,
  input  logic                  rx_sop_n,
  input  logic                  rx_eop_n,
  output logic                  tx_vld,
  input  logic                  tx_rdy,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic [REM_WIDTH-1:0]  tx_rem,
  output logic                  tx_sof_n,
  output logic                  tx_eof_n,
  output logic                  tx_sop_n,
  output logic                  tx_eop_n
);

  logic load;

  // Accept a new word when empty or when the current word leaves this cycle.
  assign rx_rdy = !tx_vld || tx_rdy;
  assign load   = rx_vld && rx_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_vld   <= 1'b0;
      tx_data  <= '0;
      tx_rem   <= '0;
      tx_sof_n <= 1'b1;
      tx_eof_n <= 1'b1;
      tx_sop_n <= 1'b1;
      tx_eop_n <= 1'b1;
    end else if (load) begin
      tx_vld   <= 1'b1;
      tx_data  <= rx_data;
      tx_rem   <= rx_rem;
      tx_sof_n <= rx_sof_n;
      tx_eof_n <= rx_eof_n;
      tx_sop_n <= rx_sop_n;
      tx_eop_n <= rx_eop_n;
    end else if (tx_rdy) begin
      tx_vld <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fl_netcope_remover.sv
//------------------------------------------------------------------------------
// Module   : fl_netcope_remover
// Brief    : Strips the leading NetCOPE header part from FrameLink frames.
//            Define FL_NETCOPE_REMOVER_STATS_EN for frame/drop counters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fl_netcope_remover
  import fl_netcope_remover_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  localparam int REM_WIDTH  = rem_width(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic [REM_WIDTH-1:0]  RX_REM,
  input  logic                  RX_SOF_N,
  input  logic                  RX_EOF_N,
  input  logic                  RX_SOP_N,
  input  logic                  RX_EOP_N,
  input  logic                  RX_SRC_RDY_N,
  output logic                  RX_DST_RDY_N,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic [REM_WIDTH-1:0]  TX_REM,
  output logic                  TX_SOF_N,
  output logic                  TX_EOF_N,
  output logic                  TX_SOP_N,
  output logic                  TX_EOP_N,
  output logic                  TX_SRC_RDY_N,
  input  logic                  TX_DST_RDY_N,
  output logic [DATA_WIDTH-1:0] HDR_DATA,
  output logic                  HDR_VLD
`ifdef FL_NETCOPE_REMOVER_STATS_EN
  ,
  input  logic                  CNT_CLEAR,
  output logic [CNT_WIDTH-1:0]  CNT_FRAMES,
  output logic [CNT_WIDTH-1:0]  CNT_DROPPED
`endif
);

  state_t state;
  logic   first;
  logic   rx_xfer;
  logic   fwd_vld;
  logic   fwd_rdy;
  logic   tx_vld;

  assign RX_DST_RDY_N = RESET || ((state == PAYLOAD) && !fwd_rdy);
  assign rx_xfer      = !RX_SRC_RDY_N && !RX_DST_RDY_N;
  // A SOF word is always header; it never reaches the output even mid-payload.
  assign fwd_vld      = !RX_SRC_RDY_N && RX_SOF_N && (state == PAYLOAD);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= WAIT_SOF;
      first    <= 1'b0;
      HDR_DATA <= '0;
      HDR_VLD  <= 1'b0;
    end else begin
      HDR_VLD <= 1'b0;
      if (rx_xfer) begin
        if (!RX_SOF_N) begin
          HDR_DATA <= RX_DATA;
          HDR_VLD  <= 1'b1;
          if (RX_EOP_N) begin
            state <= HEADER;
          end else if (!RX_EOF_N) begin
            state <= WAIT_SOF;
          end else begin
            state <= PAYLOAD;
            first <= 1'b1;
          end
        end else begin
          case (state)
            WAIT_SOF: state <= WAIT_SOF;
            HEADER: begin
              if (!RX_EOP_N) begin
                if (!RX_EOF_N) begin
                  state <= WAIT_SOF;
                end else begin
                  state <= PAYLOAD;
                  first <= 1'b1;
                end
              end
            end
            PAYLOAD: begin
              first <= 1'b0;
              if (!RX_EOF_N) begin
                state <= WAIT_SOF;
              end
            end
            default: state <= WAIT_SOF;
          endcase
        end
      end
    end
  end

  fl_out_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .REM_WIDTH  (REM_WIDTH)
  ) u_out_reg (
    .clk      (CLK),
    .rst      (RESET),
    .rx_vld   (fwd_vld),
    .rx_rdy   (fwd_rdy),
    .rx_data  (RX_DATA),
    .rx_rem   (RX_REM),
    .rx_sof_n (!first),
    .rx_eof_n (RX_EOF_N),
    .rx_sop_n (RX_SOP_N),
    .rx_eop_n (RX_EOP_N),
    .tx_vld   (tx_vld),
    .tx_rdy   (!TX_DST_RDY_N),
    .tx_data  (TX_DATA),
    .tx_rem   (TX_REM),
    .tx_sof_n (TX_SOF_N),
    .tx_eof_n (TX_EOF_N),
    .tx_sop_n (TX_SOP_N),
    .tx_eop_n (TX_EOP_N)
  );

  assign TX_SRC_RDY_N = !tx_vld;

`ifdef FL_NETCOPE_REMOVER_STATS_EN
  logic                 tx_eof_xfer;
  logic                 drop_single;
  logic                 drop_trunc;
  logic [CNT_WIDTH-1:0] frames_cnt;
  logic [CNT_WIDTH-1:0] dropped_cnt;

  assign tx_eof_xfer = tx_vld && !TX_DST_RDY_N && !TX_EOF_N;
  // Header closes with EOF: the frame had no payload part at all.
  assign drop_single = rx_xfer && !RX_EOP_N && !RX_EOF_N
                       && (!RX_SOF_N || (state == HEADER));
  assign drop_trunc  = rx_xfer && !RX_SOF_N && (state == PAYLOAD);

  always_ff @(posedge CLK) begin
    if (RESET || CNT_CLEAR) begin
      frames_cnt  <= '0;
      dropped_cnt <= '0;
    end else begin
      if (tx_eof_xfer) begin
        frames_cnt <= frames_cnt + CNT_WIDTH'(1);
      end
      dropped_cnt <= dropped_cnt + CNT_WIDTH'(drop_single) + CNT_WIDTH'(drop_trunc);
    end
  end

  assign CNT_FRAMES  = frames_cnt;
  assign CNT_DROPPED = dropped_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fl_netcope_remover.sv
//------------------------------------------------------------------------------
// Module   : tb_fl_netcope_remover
// Brief    : Scoreboard bench for fl_netcope_remover (FL_NETCOPE_REMOVER_STATS_EN aware).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_fl_netcope_remover;

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  rem;
    logic        sof_n;
    logic        eof_n;
    logic        sop_n;
    logic        eop_n;
  } word_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [63:0] RX_DATA;
  logic [2:0]  RX_REM;
  logic        RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N, RX_SRC_RDY_N, RX_DST_RDY_N;
  logic [63:0] TX_DATA;
  logic [2:0]  TX_REM;
  logic        TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N, TX_SRC_RDY_N;
  logic        TX_DST_RDY_N = 1'b1;
  logic [63:0] HDR_DATA;
  logic        HDR_VLD;
`ifdef FL_NETCOPE_REMOVER_STATS_EN
  logic        CNT_CLEAR;
  logic [31:0] CNT_FRAMES, CNT_DROPPED;
  logic [31:0] exp_frames = '0;
  logic [31:0] exp_dropped = '0;
`endif

  word_t       exp_q[$];
  logic [63:0] hdr_q[$];
  int          errors = 0;
  int          checks = 0;
  int          tx_mode = 2;   // 0 always ready, 1 toggling, 2 stalled
  bit          burst = 1'b0;
  int          bubbles = 0;
  int          hdr_pulses = 0;

  always #5 CLK = ~CLK;

  fl_netcope_remover #(.DATA_WIDTH(64)) dut (
    .CLK(CLK), .RESET(RESET),
    .RX_DATA(RX_DATA), .RX_REM(RX_REM), .RX_SOF_N(RX_SOF_N), .RX_EOF_N(RX_EOF_N),
    .RX_SOP_N(RX_SOP_N), .RX_EOP_N(RX_EOP_N), .RX_SRC_RDY_N(RX_SRC_RDY_N),
    .RX_DST_RDY_N(RX_DST_RDY_N),
    .TX_DATA(TX_DATA), .TX_REM(TX_REM), .TX_SOF_N(TX_SOF_N), .TX_EOF_N(TX_EOF_N),
    .TX_SOP_N(TX_SOP_N), .TX_EOP_N(TX_EOP_N), .TX_SRC_RDY_N(TX_SRC_RDY_N),
    .TX_DST_RDY_N(TX_DST_RDY_N),
    .HDR_DATA(HDR_DATA), .HDR_VLD(HDR_VLD)
`ifdef FL_NETCOPE_REMOVER_STATS_EN
    , .CNT_CLEAR(CNT_CLEAR), .CNT_FRAMES(CNT_FRAMES), .CNT_DROPPED(CNT_DROPPED)
`endif
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // TX backpressure pattern, updated just after each rising edge
  initial forever begin
    @(posedge CLK);
    #1;
    case (tx_mode)
      0:       TX_DST_RDY_N = 1'b0;
      1:       TX_DST_RDY_N = ~TX_DST_RDY_N;
      default: TX_DST_RDY_N = 1'b1;
    endcase
  end

  // Monitor: pops expectations whenever the DUT transfers a word or pulses HDR_VLD
  word_t cur, prev_word;
  bit    prev_stall = 1'b0;
  bit    in_frame = 1'b0;
  initial forever begin
    @(negedge CLK);
    if (RESET) begin
      prev_stall = 1'b0;
      in_frame   = 1'b0;
    end else begin
      cur = {TX_DATA, TX_REM, TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N};
      if (prev_stall) begin
        check("tx_hold_valid", TX_SRC_RDY_N, 1'b0);
        check("tx_hold_word", cur, prev_word);
      end
      if (burst && in_frame && TX_SRC_RDY_N) bubbles++;
      if (!TX_SRC_RDY_N && !TX_DST_RDY_N) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got %0h expected no word", cur);
        end else begin
          check("tx_word", cur, exp_q.pop_front());
        end
        in_frame = TX_EOF_N;
      end
      prev_stall = !TX_SRC_RDY_N && TX_DST_RDY_N;
      prev_word  = cur;
      if (HDR_VLD) begin
        hdr_pulses++;
        if (hdr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL hdr_unexpected: got %0h expected no pulse", HDR_DATA);
        end else begin
          check("hdr_data", HDR_DATA, hdr_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [63:0] d, input logic [2:0] r,
                      input logic sof, input logic eof, input logic sop, input logic eop);
    logic acc;
    acc = 1'b0;
    RX_DATA = d; RX_REM = r;
    RX_SOF_N = ~sof; RX_EOF_N = ~eof; RX_SOP_N = ~sop; RX_EOP_N = ~eop;
    RX_SRC_RDY_N = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      acc = !RX_DST_RDY_N;
      @(posedge CLK);
      #1;
      if (acc) break;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL rx_accept_timeout: got no accept expected accept of %0h", d);
    end
    RX_SRC_RDY_N = 1'b1;
  endtask

  // Header of nhdr words then up to three payload parts of p0/p1/p2 words
  task automatic send_frame(input logic [63:0] hdr0, input int nhdr,
                            input int p0, input int p1, input int p2, input logic [7:0] id);
    int       parts[3];
    int       np;
    bit       first;
    logic [63:0] d;
    logic [2:0]  r;
    bit       sop, eop, eof;
    parts[0] = p0; parts[1] = p1; parts[2] = p2;
    np = (p0 > 0 ? 1 : 0) + (p1 > 0 ? 1 : 0) + (p2 > 0 ? 1 : 0);
    first = 1'b1;
    hdr_q.push_back(hdr0);
    for (int i = 0; i < nhdr; i++)
      send((i == 0) ? hdr0 : {id, 8'hEE, 48'(i)}, 3'd7, i == 0,
           (np == 0) && (i == nhdr - 1), i == 0, i == nhdr - 1);
`ifdef FL_NETCOPE_REMOVER_STATS_EN
    if (np == 0) exp_dropped++; else exp_frames++;
`endif
    for (int p = 0; p < np; p++) begin
      for (int w = 0; w < parts[p]; w++) begin
        d   = {id, 8'(p), 16'hC0DE, 32'(w)};
        sop = (w == 0);
        eop = (w == parts[p] - 1);
        eof = eop && (p == np - 1);
        r   = eop ? 3'(id + 8'(p)) : 3'd7;
        exp_q.push_back({d, r, ~first, ~eof, ~sop, ~eop});
        first = 1'b0;
        send(d, r, 1'b0, eof, sop, eop);
      end
    end
  endtask

  time t0;
  int  pulses_before;

  initial begin
    RESET = 1'b1;
    RX_DATA = '0; RX_REM = '0;
    RX_SOF_N = 1'b1; RX_EOF_N = 1'b1; RX_SOP_N = 1'b1; RX_EOP_N = 1'b1;
    RX_SRC_RDY_N = 1'b1;
`ifdef FL_NETCOPE_REMOVER_STATS_EN
    CNT_CLEAR = 1'b0;
`endif
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_tx_src_rdy_n", TX_SRC_RDY_N, 1'b1);
    check("rst_tx_delims_n", {TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N}, 4'hF);
    check("rst_tx_data_rem", {TX_DATA, TX_REM}, '0);
    check("rst_hdr", {HDR_DATA, HDR_VLD}, '0);
    check("rst_rx_dst_rdy_n", RX_DST_RDY_N, 1'b1);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    check("post_rst_rx_dst_rdy_n", RX_DST_RDY_N, 1'b0);
    @(posedge CLK);
    #1;

    // 2-word header accepted while TX is stalled, then 3-word payload
    pulses_before = hdr_pulses;
    hdr_q.push_back(64'hA5A5_0000_0000_0001);
    send(64'hA5A5_0000_0000_0001, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    send(64'h0000_0000_0000_0002, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    tx_mode = 0;
    exp_q.push_back({64'h1111_0000_0000_0001, 3'd7, 4'b0101});
    send(64'h1111_0000_0000_0001, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_q.push_back({64'h1111_0000_0000_0002, 3'd7, 4'b1111});
    send(64'h1111_0000_0000_0002, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back({64'h1111_0000_0000_0003, 3'd5, 4'b1010});
    send(64'h1111_0000_0000_0003, 3'd5, 1'b0, 1'b1, 1'b0, 1'b1);
`ifdef FL_NETCOPE_REMOVER_STATS_EN
    exp_frames++;
`endif
    repeat (3) @(posedge CLK);
    #1;
    check("two_part_hdr_data", HDR_DATA, 64'hA5A5_0000_0000_0001);
    check("two_part_hdr_pulses", hdr_pulses - pulses_before, 1);
    check("two_part_tx_drained", exp_q.size(), 0);

    // single-part frame is dropped entirely
    send_frame(64'h5151_0000_0000_00AA, 1, 0, 0, 0, 8'h22);
    repeat (3) @(posedge CLK);
    #1;
`ifdef FL_NETCOPE_REMOVER_STATS_EN
    check("single_part_dropped", CNT_DROPPED, 32'd1);
`endif

    // 3-part frame under toggling backpressure
    tx_mode = 1;
    send_frame(64'h3333_0000_0000_0003, 2, 3, 2, 0, 8'h33);
    tx_mode = 0;

    // SOF inside payload truncates the frame in flight
    hdr_q.push_back(64'hDEAD_0000_0000_0007);
    send(64'hDEAD_0000_0000_0007, 3'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    exp_q.push_back({64'h7777_0000_0000_0001, 3'd7, 4'b0101});
    send(64'h7777_0000_0000_0001, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_q.push_back({64'h7777_0000_0000_0002, 3'd2, 4'b1111});
    send(64'h7777_0000_0000_0002, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FL_NETCOPE_REMOVER_STATS_EN
    exp_dropped++;
`endif
    send_frame(64'h4444_0000_0000_0004, 1, 1, 0, 0, 8'h44);
    repeat (3) @(posedge CLK);
    #1;
`ifdef FL_NETCOPE_REMOVER_STATS_EN
    check("cnt_frames_mid", CNT_FRAMES, exp_frames);
    check("cnt_dropped_mid", CNT_DROPPED, exp_dropped);
    CNT_CLEAR = 1'b1;
    @(posedge CLK);
    #1;
    CNT_CLEAR = 1'b0;
    exp_frames = '0;
    exp_dropped = '0;
`endif

    // 100 back-to-back frames at full rate
    burst = 1'b1;
    t0 = $time;
    for (int f = 0; f < 100; f++)
      send_frame({8'h90, 8'(f), 48'h0}, 1, 2, 0, 0, 8'(f));
    check("burst_rx_cycles", ($time - t0) / 10, 300);
    repeat (3) @(posedge CLK);
    #1;
    burst = 1'b0;
    check("burst_tx_bubbles", bubbles, 0);
`ifdef FL_NETCOPE_REMOVER_STATS_EN
    check("burst_cnt_frames", CNT_FRAMES, 32'd100);

    // counter wrap and clear priority over a simultaneous EOF transfer
    @(negedge CLK);
    force dut.frames_cnt = 32'hFFFF_FFFF;
    @(posedge CLK);
    #1;
    release dut.frames_cnt;
    send_frame(64'hF0F0_0000_0000_0001, 1, 2, 0, 0, 8'h55);
    repeat (3) @(posedge CLK);
    #1;
    check("cnt_frames_wrap", CNT_FRAMES, 32'd0);
    send_frame(64'hF0F0_0000_0000_0002, 1, 2, 0, 0, 8'h56);
    CNT_CLEAR = 1'b1;
    @(posedge CLK);
    #1;
    CNT_CLEAR = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("cnt_clear_priority", CNT_FRAMES, 32'd0);
    exp_frames = '0;
`endif

    // reset while a payload word sits stalled in the output register
    tx_mode = 2;
    hdr_q.push_back(64'hBEEF_0000_0000_0001);
    send(64'hBEEF_0000_0000_0001, 3'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    send(64'h6666_0000_0000_0001, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    check("midrst_rx_dst_rdy_n", RX_DST_RDY_N, 1'b1);
    check("midrst_tx_src_rdy_n", TX_SRC_RDY_N, 1'b1);
    RESET = 1'b0;
    tx_mode = 0;
    send(64'hBAD0_0000_0000_0001, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    send(64'hBAD0_0000_0000_0002, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1);
    send(64'hBAD0_0000_0000_0003, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(64'h7070_0000_0000_0001, 1, 2, 0, 0, 8'h77);
    repeat (4) @(posedge CLK);
    #1;
`ifdef FL_NETCOPE_REMOVER_STATS_EN
    check("post_rst_cnt_frames", CNT_FRAMES, 32'd1);
    check("post_rst_cnt_dropped", CNT_DROPPED, 32'd0);
`endif

    repeat (6) @(posedge CLK);
    #1;
    check("tx_queue_drained", exp_q.size(), 0);
    check("hdr_queue_drained", hdr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
